// File: rtl/mem_subword_access_unit.sv
// Sub-word load/store unit on data memory port A: byte/half stores become
// read-modify-write (one stall cycle), loads are extended and registered.
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   req_*                    memory request from EX/MEM
//   stall                    hold EX/MEM and upstream this cycle
//   mem_addr/wdata/we/rdata  memory port A (rdata valid same cycle)
//   ld_data, ld_valid        registered load result for MEM/WB
//   misalign_err             sticky misaligned/dropped-store flag
module mem_subword_access_unit #(
    parameter bit RMW_EN    = 1'b1,
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    input  logic        req_read,
    input  logic        req_half,
    input  logic        req_byte,
    input  logic        req_unsigned,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign_err
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;
    logic        err_q, err_d;

    logic        is_store, is_load, is_sub, mis;
    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] mask, ins, merged, ext;

    // Request decode. A half access ignores req_byte; a misaligned
    // half still uses lane addr[1] because addr[0] is forced to zero.
    always_comb begin
        is_store = req_valid & req_write;
        is_load  = req_valid & req_read & ~req_write;
        is_sub   = req_half | req_byte;
        if (req_half)
            mis = ALIGN_CHK & req_addr[0];
        else
            mis = ALIGN_CHK & ~req_byte & (req_addr[1:0] != 2'b00);
        lane  = req_half ? {req_addr[1], 1'b0} : req_addr[1:0];
        shamt = {lane, 3'b000};
    end

    // Lane extraction and extension for loads.
    always_comb begin
        unique case (req_addr[1:0])
            2'd0:    lb = mem_rdata[7:0];
            2'd1:    lb = mem_rdata[15:8];
            2'd2:    lb = mem_rdata[23:16];
            default: lb = mem_rdata[31:24];
        endcase
        lh = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (req_half)
            ext = req_unsigned ? {16'h0, lh} : {{16{lh[15]}}, lh};
        else if (req_byte)
            ext = req_unsigned ? {24'h0, lb} : {{24{lb[7]}}, lb};
        else
            ext = mem_rdata;
    end

    // Store merge: replace the target lane of the current word.
    always_comb begin
        mask   = (req_half ? 32'h0000_ffff : 32'h0000_00ff) << shamt;
        ins    = (req_half ? {16'h0, req_wdata[15:0]}
                           : {24'h0, req_wdata[7:0]}) << shamt;
        merged = (mem_rdata & ~mask) | (ins & mask);
    end

    always_comb begin
        state_d    = state_q;
        merge_d    = merge_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        err_d      = err_q;
        stall      = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {req_addr[31:2], 2'b00};
        mem_wdata  = req_wdata;
        unique case (state_q)
            IDLE: begin
                if (req_valid & (req_read | req_write) & mis)
                    err_d = 1'b1;
                if (is_store) begin
                    if (!is_sub) begin
                        mem_we = 1'b1;
                    end else if (RMW_EN) begin
                        stall   = 1'b1;
                        merge_d = merged;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (is_load) begin
                    ld_valid_d = 1'b1;
                    ld_data_d  = ext;
                end
            end
            WRITE: begin
                // The held request is the one being completed.
                mem_we    = 1'b1;
                mem_wdata = merge_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset blanks the port, abandoning any pending merged write.
        if (Rst) begin
            stall     = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = 32'h0;
            mem_wdata = 32'h0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            merge_q    <= 32'h0;
            ld_data_q  <= 32'h0;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            merge_q    <= merge_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            err_q      <= err_d;
        end
    end

    assign ld_data      = ld_data_q;
    assign ld_valid     = ld_valid_q;
    assign misalign_err = err_q;

endmodule
